// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a parallel word as start, LSB-first data,
// optional parity and stop bit, one bit per clk. Parity comes from an external calculator.

module uart_tx_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic tx_out,
    input logic busy,
    input logic par_calc_en
);

    // line must idle high whenever no frame is in progress
    a_idle_high: assert property (@(posedge clk) disable iff (!rst) !busy |-> tx_out);

    // the parity enable only fires inside a frame (its START cycle)
    a_en_in_frame: assert property (@(posedge clk) disable iff (!rst) par_calc_en |-> busy);

    // the parity enable is a single-cycle pulse
    a_en_pulse: assert property (@(posedge clk) disable iff (!rst) par_calc_en |=> !par_calc_en);

endmodule

module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  parity_bit,
    output logic [DATA_WIDTH-1:0] par_calc_data,
    output logic                  par_calc_en,
    output logic                  par_calc_typ,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_s;
    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] data_s;
    logic                  par_en_r;
    logic                  par_en_s;
    logic                  typ_r;
    logic                  typ_s;
    logic                  en_r;
    logic                  en_s;
    logic                  tx_r;
    logic                  tx_s;
    logic                  busy_r;
    logic                  busy_s;
    logic                  accept_s;

    // next-state and bit-counter logic; a request is only taken in IDLE or at the end of STOP
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (data_valid) begin
                    state_s  = START;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            START: begin
                state_s = DATA;
                cnt_s   = {CNT_W{1'b0}};
            end
            DATA: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = par_en_r ? PARITY : STOP;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = DATA;
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            PARITY: begin
                state_s = STOP;
            end
            STOP: begin
                if (data_valid) begin
                    state_s  = START;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // frame configuration is captured once per accepted request and held for the whole frame
    always_comb begin
        data_s   = data_r;
        par_en_s = par_en_r;
        typ_s    = typ_r;
        if (accept_s) begin
            data_s   = p_data;
            par_en_s = par_en;
            typ_s    = par_typ;
        end else begin
            data_s   = data_r;
            par_en_s = par_en_r;
            typ_s    = typ_r;
        end
    end

    // output decode from the upcoming state so every output is a register
    always_comb begin
        en_s   = accept_s;
        busy_s = (state_s != IDLE);
        tx_s   = 1'b1;
        case (state_s)
            IDLE:    tx_s = 1'b1;
            START:   tx_s = 1'b0;
            DATA:    tx_s = data_s[cnt_s];
            PARITY:  tx_s = parity_bit;
            STOP:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            data_r   <= {DATA_WIDTH{1'b0}};
            par_en_r <= 1'b0;
            typ_r    <= 1'b0;
            en_r     <= 1'b0;
            tx_r     <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            data_r   <= data_s;
            par_en_r <= par_en_s;
            typ_r    <= typ_s;
            en_r     <= en_s;
            tx_r     <= tx_s;
            busy_r   <= busy_s;
        end
    end

    assign par_calc_data = data_r;
    assign par_calc_en   = en_r;
    assign par_calc_typ  = typ_r;
    assign tx_out        = tx_r;
    assign busy          = busy_r;

    uart_tx_ctrl_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .tx_out      (tx_r),
        .busy        (busy_r),
        .par_calc_en (en_r)
    );

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a frame-queue reference model checked every cycle,
// plus directed frames with literal expected bit sequences.

module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       parity_result;
    logic [7:0] par_calc_data;
    logic       par_calc_en;
    logic       par_calc_typ;
    logic       tx_out;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .p_data        (p_data),
        .data_valid    (data_valid),
        .par_en        (par_en),
        .par_typ       (par_typ),
        .parity_bit    (parity_result),
        .par_calc_data (par_calc_data),
        .par_calc_en   (par_calc_en),
        .par_calc_typ  (par_calc_typ),
        .tx_out        (tx_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // TX parity calculator: registered result, updated on the enable pulse
    always @(posedge clk) begin
        if (!rst) parity_result <= 1'b0;
        else if (par_calc_en) parity_result <= (^par_calc_data) ^ par_calc_typ;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole frame as a bit string, first transmitted bit in the MSB position
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic en,
                                               input logic typ, output int len);
        logic [15:0] f;
        f = 16'h0;
        len = 0;
        f = {f[14:0], 1'b0}; len++;
        for (int i = 0; i < 8; i++) begin
            f = {f[14:0], d[i]}; len++;
        end
        if (en) begin
            f = {f[14:0], (^d) ^ typ}; len++;
        end
        f = {f[14:0], 1'b1}; len++;
        return f;
    endfunction

    // Reference model: queue of line bits still to send; front is the bit on the line now
    logic q[$];
    logic       exp_tx   = 1'b1;
    logic       exp_busy = 1'b0;
    logic       exp_en   = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_typ  = 1'b0;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("tx_out", 32'(tx_out), 32'(exp_tx));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("par_calc_en", 32'(par_calc_en), 32'(exp_en));
            chk("par_calc_data", 32'(par_calc_data), 32'(exp_data));
            chk("par_calc_typ", 32'(par_calc_typ), 32'(exp_typ));
            if (!rst) begin
                q.delete();
                exp_en   = 1'b0;
                exp_data = 8'h00;
                exp_typ  = 1'b0;
            end else begin
                if (q.size() > 0) void'(q.pop_front());
                exp_en = 1'b0;
                if (q.size() == 0 && data_valid) begin
                    logic [15:0] f;
                    int len;
                    f = frame_bits(p_data, par_en, par_typ, len);
                    for (int i = len - 1; i >= 0; i--) q.push_back(f[i]);
                    exp_en   = 1'b1;
                    exp_data = p_data;
                    exp_typ  = par_typ;
                end
            end
            exp_tx   = (q.size() > 0) ? q[0] : 1'b1;
            exp_busy = (q.size() > 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input logic en,
                             input logic typ, input logic [31:0] exp_seq, input int len);
        logic [31:0] seq;
        int nb;
        int ne;
        p_data = d; par_en = en; par_typ = typ; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        p_data  = 8'($urandom);
        par_en  = 1'($urandom);
        par_typ = 1'($urandom);
        seq = 32'h0; nb = 0; ne = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            seq = {seq[30:0], tx_out};
            nb += int'(busy);
            ne += int'(par_calc_en);
        end
        @(negedge clk);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        chk({name, "_seq"}, seq, exp_seq);
        chk({name, "_busy_len"}, 32'(nb), 32'(len));
        chk({name, "_en_pulses"}, 32'(ne), 32'd1);
        tick();
    endtask

    initial begin
        logic [31:0] seq;
        logic [15:0] f;
        int len;
        int n1;
        int nb;
        int ne;
        rst = 1'b0; data_valid = 1'b0; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("reset_tx", 32'(tx_out), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_en", 32'(par_calc_en), 32'd0);
        tick();
        rst = 1'b1;

        n1 = 0;
        repeat (20) begin
            @(negedge clk);
            n1 += int'(tx_out);
        end
        tick();
        chk("idle_tx_high", 32'(n1), 32'd20);

        f = frame_bits(8'hA5, 1'b1, 1'b0, len);
        chk("model_a5_bits", 32'(f), 32'h295);
        chk("model_a5_len", 32'(len), 32'd11);
        f = frame_bits(8'hFF, 1'b0, 1'b0, len);
        chk("model_ff_bits", 32'(f), 32'h1FF);
        chk("model_ff_len", 32'(len), 32'd10);

        run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 32'b01010010101, 11);
        run_frame("01_odd", 8'h01, 1'b1, 1'b1, 32'b01000000001, 11);
        run_frame("03_odd", 8'h03, 1'b1, 1'b1, 32'b01100000011, 11);
        run_frame("ff_nopar", 8'hFF, 1'b0, 1'b0, 32'b0111111111, 10);

        // back-to-back frames with data_valid held high
        p_data = 8'h55; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
        tick();
        p_data = 8'hAA;
        seq = 32'h0; nb = 0; ne = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            seq = {seq[30:0], tx_out};
            nb += int'(busy);
            ne += int'(par_calc_en);
            if (i == 10) begin
                tick();
                data_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_busy_after", 32'(busy), 32'd0);
        chk("b2b_seq", seq, 32'b0101010100100101010101);
        chk("b2b_busy_len", 32'(nb), 32'd22);
        chk("b2b_en_pulses", 32'(ne), 32'd2);
        tick();

        // reset asserted during data bit 3
        p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("bit3_value", 32'(tx_out), 32'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", 32'(tx_out), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_en", 32'(par_calc_en), 32'd0);
        tick();
        run_frame("after_rst", 8'hA5, 1'b1, 1'b0, 32'b01010010101, 11);

        // randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            data_valid = ($urandom_range(0, 3) != 0);
            p_data     = 8'($urandom);
            par_en     = 1'($urandom);
            par_typ    = 1'($urandom);
            rst        = ($urandom_range(0, 149) != 0);
            tick();
        end
        rst = 1'b1;
        data_valid = 1'b0;
        repeat (14) tick();
        @(negedge clk);
        chk("drain_idle_busy", 32'(busy), 32'd0);
        chk("drain_idle_tx", 32'(tx_out), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
